shift_cipher_lanes: RTL and testbench

//  Parametrised successor to the single-byte decrypt shift stage. Applies a Caesar shift to LANES bytes per beat,

---
 rtl/shift_cipher_lanes_pkg.sv | 22 ++
 rtl/shift_cipher_lanes_byte_rot.sv | 26 ++
 rtl/shift_cipher_lanes.sv | 114 +++++++++++
 tb/tb_shift_cipher_lanes.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_cipher_lanes_pkg.sv
// Shared constants, types and helpers for the multi-lane Caesar shift cipher.
package cipher_pkg;

  localparam int         ALPHA_LEN  = 26;
  localparam logic [7:0] ASCII_UP_A = 8'h41;
  localparam logic [7:0] ASCII_LO_A = 8'h61;

  typedef enum logic [1:0] {CLS_OTHER, CLS_UPPER, CLS_LOWER} char_cls_t;
  typedef enum logic {MODE_ENC, MODE_DEC} cipher_mode_t;

  // Wide input so sums of key, lane offsets and steps reduce without truncation.
  function automatic logic [4:0] mod26(input logic [15:0] x);
    return 5'(x % 16'(ALPHA_LEN));
  endfunction

  function automatic char_cls_t classify(input logic [7:0] b);
    if (b >= ASCII_UP_A && b <= ASCII_UP_A + 8'd25) return CLS_UPPER;
    if (b >= ASCII_LO_A && b <= ASCII_LO_A + 8'd25) return CLS_LOWER;
    return CLS_OTHER;
  endfunction

endpackage

// File: rtl/shift_cipher_lanes_byte_rot.sv
// Combinational single-lane rotate; letters shift within their own case, everything else passes through.
module cipher_byte_rot
  import cipher_pkg::*;
(
  input  logic [7:0]   byte_in,
  input  char_cls_t    cls,
  input  logic [4:0]   key,
  input  cipher_mode_t mode,
  input  logic         en,
  output logic [7:0]   byte_out
);

  logic [7:0]  base;
  logic [15:0] idx;
  logic [4:0]  rot;

  always_comb begin
    base = (cls == CLS_LOWER) ? ASCII_LO_A : ASCII_UP_A;
    idx  = 16'(byte_in - base);
    if (mode == MODE_ENC) rot = mod26(idx + 16'(key));
    else                  rot = mod26(idx + 16'(ALPHA_LEN) - 16'(key));
    byte_out = byte_in;
    if (en && cls != CLS_OTHER) byte_out = base + 8'(rot);
  end

endmodule

// File: rtl/shift_cipher_lanes.sv
// LANES-wide Caesar/rolling-key cipher behind a 2-stage stall-capable valid/ready pipeline.
module shift_cipher_lanes
  import cipher_pkg::*;
#(
  parameter int LANES = 4,
  parameter int KEY_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               mode,
  input  logic               shift_en,
  input  logic               roll_en,
  input  logic [KEY_W-1:0]   roll_step,
  input  logic               key_load,
  input  logic [KEY_W-1:0]   key_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [4:0]         cur_key
);

  logic               v1_q, v1_d, v2_q, v2_d;
  logic [4:0]         key_q, key_d;
  logic [8*LANES-1:0] data1_q, data1_d;
  char_cls_t          cls1_q [LANES];
  char_cls_t          cls1_d [LANES];
  logic [4:0]         k1_q [LANES];
  logic [4:0]         k1_d [LANES];
  cipher_mode_t       mode1_q, mode1_d;
  logic               shen1_q, shen1_d;
  logic [8*LANES-1:0] out_data_q, out_data_d;
  logic [8*LANES-1:0] rot_data;
  logic               s1_adv, s2_adv, accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cipher_byte_rot u_rot (
      .byte_in  (data1_q[8*g +: 8]),
      .cls      (cls1_q[g]),
      .key      (k1_q[g]),
      .mode     (mode1_q),
      .en       (shen1_q),
      .byte_out (rot_data[8*g +: 8])
    );
  end

  always_comb begin
    s2_adv   = !v2_q || out_ready;
    s1_adv   = !v1_q || s2_adv;
    in_ready = !rst && s1_adv;
    accept   = in_valid && in_ready;

    v1_d       = v1_q;
    v2_d       = v2_q;
    key_d      = key_q;
    data1_d    = data1_q;
    cls1_d     = cls1_q;
    k1_d       = k1_q;
    mode1_d    = mode1_q;
    shen1_d    = shen1_q;
    out_data_d = out_data_q;

    if (s1_adv) begin
      v1_d = accept;
      if (accept) begin
        data1_d = in_data;
        mode1_d = cipher_mode_t'(mode);
        shen1_d = shift_en;
        for (int i = 0; i < LANES; i++) begin
          cls1_d[i] = classify(in_data[8*i +: 8]);
          k1_d[i]   = mod26(16'(key_q) + (roll_en ? 16'(i) * 16'(roll_step) : 16'd0));
        end
      end
    end

    if (s2_adv) begin
      v2_d = v1_q;
      if (v1_q) out_data_d = rot_data;
    end

    // Lane keys above were built from the old key, so a same-cycle load only affects later beats.
    if (key_load)              key_d = mod26(16'(key_in));
    else if (accept && roll_en) key_d = mod26(16'(key_q) + 16'(LANES) * 16'(roll_step));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      key_q      <= 5'd0;
      out_data_q <= '0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      key_q      <= key_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    data1_q <= data1_d;
    cls1_q  <= cls1_d;
    k1_q    <= k1_d;
    mode1_q <= mode1_d;
    shen1_q <= shen1_d;
  end

  assign out_valid = v2_q;
  assign out_data  = out_data_q;
  assign cur_key   = key_q;

endmodule

// File: tb/tb_shift_cipher_lanes.sv
// Directed bench for shift_cipher_lanes (LANES=4) with hand-computed expected beats.
module tb_shift_cipher_lanes;

  localparam int LANES = 4;
  localparam int KEY_W = 5;

  logic               clk, rst, in_valid, in_ready, mode, shift_en, roll_en;
  logic               key_load, out_valid, out_ready;
  logic [8*LANES-1:0] in_data, out_data;
  logic [KEY_W-1:0]   roll_step, key_in;
  logic [4:0]         cur_key;
  int                 checkCount, failCount;

  shift_cipher_lanes #(.LANES(LANES), .KEY_W(KEY_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .shift_en  (shift_en),
    .roll_en   (roll_en),
    .roll_step (roll_step),
    .key_load  (key_load),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cur_key   (cur_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] data, input logic modeIn, input logic shiftIn,
                               input logic rollIn, input logic [4:0] stepIn);
    int n;
    in_data   = data;
    mode      = modeIn;
    shift_en  = shiftIn;
    roll_en   = rollIn;
    roll_step = stepIn;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    if (n >= 20) checkOutput("accept_timeout", 64'(n), 64'd0);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic expectBeat(input string tag, input logic [31:0] expected);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      tick;
      n++;
    end
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput(tag, 64'(out_data), 64'(expected));
    tick;
  endtask

  task automatic loadKey(input logic [4:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick;
    key_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; shift_en = 1'b0;
    roll_en = 1'b0; roll_step = '0; key_load = 1'b0; key_in = '0; out_ready = 1'b1;

    tick;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_cur_key", 64'(cur_key), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

    // key 3 encrypt "ABz5" -> "DEc5", with latency check
    loadKey(5'd3);
    checkOutput("key3", 64'(cur_key), 64'd3);
    applyStimulus(32'h357A4241, 1'b0, 1'b1, 1'b0, 5'd0);
    checkOutput("lat_not_yet", 64'(out_valid), 64'd0);
    tick;
    checkOutput("lat_valid", 64'(out_valid), 64'd1);
    checkOutput("enc_ABz5", 64'(out_data), 64'h35634544);
    tick;
    checkOutput("drained", 64'(out_valid), 64'd0);

    // shift disabled passes bytes through even with a nonzero key
    applyStimulus(32'h357A4241, 1'b0, 1'b0, 1'b0, 5'd0);
    expectBeat("shift_off", 32'h357A4241);

    // key 1 decrypt "aAzZ" -> "zZyY"
    loadKey(5'd1);
    applyStimulus(32'h5A7A4161, 1'b1, 1'b1, 1'b0, 5'd0);
    expectBeat("dec_aAzZ", 32'h59795A7A);

    // key 0 leaves letters unchanged
    loadKey(5'd0);
    applyStimulus(32'h357A4241, 1'b0, 1'b1, 1'b0, 5'd0);
    expectBeat("key0", 32'h357A4241);

    loadKey(5'd27);
    checkOutput("key27_wrap", 64'(cur_key), 64'd1);

    // rolling key, step 1, two back-to-back "AAAA" beats
    loadKey(5'd0);
    applyStimulus(32'h41414141, 1'b0, 1'b1, 1'b1, 5'd1);
    checkOutput("roll_key4", 64'(cur_key), 64'd4);
    applyStimulus(32'h41414141, 1'b0, 1'b1, 1'b1, 5'd1);
    checkOutput("roll_key8", 64'(cur_key), 64'd8);
    expectBeat("roll_ABCD", 32'h44434241);
    expectBeat("roll_EFGH", 32'h48474645);
    tick;
    checkOutput("roll_idle_key", 64'(cur_key), 64'd8);
    roll_en = 1'b0;

    // backpressure: out_ready low, three beats offered, only two held
    loadKey(5'd2);
    out_ready = 1'b0;
    applyStimulus(32'h41414141, 1'b0, 1'b1, 1'b0, 5'd0);
    applyStimulus(32'h42424242, 1'b0, 1'b1, 1'b0, 5'd0);
    in_data  = 32'h64636261;
    in_valid = 1'b1;
    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("stall_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_hold_data", 64'(out_data), 64'h43434343);
      checkOutput("stall_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("unstall_in_ready", 64'(in_ready), 64'd1);
    tick;
    in_valid = 1'b0;
    expectBeat("stall_beat2", 32'h44444444);
    expectBeat("stall_beat3", 32'h66656463);
    checkOutput("stall_no_dup", 64'(out_valid), 64'd0);

    // key_load alongside an accepted beat: that beat uses key 2, the next uses key 5
    key_in   = 5'd5;
    key_load = 1'b1;
    applyStimulus(32'h41414141, 1'b0, 1'b1, 1'b0, 5'd0);
    key_load = 1'b0;
    checkOutput("load_same_cycle_key", 64'(cur_key), 64'd5);
    applyStimulus(32'h41414141, 1'b0, 1'b1, 1'b0, 5'd0);
    expectBeat("old_key_beat", 32'h43434343);
    expectBeat("new_key_beat", 32'h46464646);

    // reset with two beats in flight
    applyStimulus(32'h41414141, 1'b0, 1'b1, 1'b0, 5'd0);
    applyStimulus(32'h42424242, 1'b0, 1'b1, 1'b0, 5'd0);
    checkOutput("inflight_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_cur_key", 64'(cur_key), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick;
    checkOutput("midrst_no_stale", 64'(out_valid), 64'd0);
    loadKey(5'd1);
    applyStimulus(32'h357A4241, 1'b0, 1'b1, 1'b0, 5'd0);
    expectBeat("after_rst", 32'h35614342);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
